// File: rtl/phmm_diag_sched.sv
// Anti-diagonal wavefront scheduler for the PairHMM PE array. It walks every diagonal of an
// R x H matrix and issues NUM_PE-row beats, with an optional gap between diagonals.
module phmm_diag_sched #(
    parameter int unsigned NUM_PE  = 4,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned DEP_LAT = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  rd_len,
    input  logic [LEN_W-1:0]  hap_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LEN_W:0]    out_diag,
    output logic [LEN_W-1:0]  out_row0,
    output logic [NUM_PE-1:0] out_mask,
    output logic              out_last
);
    localparam int unsigned DW      = LEN_W + 1;
    // Wide enough that row0 + NUM_PE never wraps.
    localparam int unsigned SW      = DW + $clog2(NUM_PE + 1);
    localparam int unsigned GW      = (DEP_LAT > 1) ? $clog2(DEP_LAT) : 1;
    localparam int unsigned GapInit = (DEP_LAT > 0) ? DEP_LAT - 1 : 0;

    typedef enum logic [1:0] {StIdle, StRun, StGap, StFin} state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  r_q, r_d;
    logic [LEN_W-1:0]  h_q, h_d;
    logic [DW-1:0]     diag_q, diag_d;
    logic [LEN_W-1:0]  row0_q, row0_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              rej_q, rej_d;

    logic [DW-1:0]     r_ext, h_ext, i_max, diag_inc, i_min_nxt, diag_fin;
    logic [SW-1:0]     row_sum;
    logic              last_beat;
    logic [NUM_PE-1:0] mask;

    always_comb begin
        r_ext     = {1'b0, r_q};
        h_ext     = {1'b0, h_q};
        diag_inc  = diag_q + DW'(1);
        diag_fin  = r_ext + h_ext - DW'(2);
        i_max     = (diag_q < r_ext - DW'(1)) ? diag_q : r_ext - DW'(1);
        i_min_nxt = (diag_inc > h_ext - DW'(1)) ? diag_inc - (h_ext - DW'(1)) : '0;
        row_sum   = SW'(row0_q) + SW'(NUM_PE);
        last_beat = row_sum > SW'(i_max);
        mask      = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            mask[k] = (SW'(row0_q) + SW'(k)) <= SW'(i_max);
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        h_d     = h_q;
        diag_d  = diag_q;
        row0_d  = row0_q;
        gap_d   = gap_q;
        rej_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (rd_len == '0 || hap_len == '0) begin
                        rej_d = 1'b1;
                    end else begin
                        r_d     = rd_len;
                        h_d     = hap_len;
                        diag_d  = '0;
                        row0_d  = '0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (out_ready) begin
                    if (!last_beat) begin
                        row0_d = row_sum[LEN_W-1:0];
                    end else if (diag_q == diag_fin) begin
                        state_d = StFin;
                    end else if (DEP_LAT == 0) begin
                        diag_d = diag_inc;
                        row0_d = i_min_nxt[LEN_W-1:0];
                    end else begin
                        gap_d   = GW'(GapInit);
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    diag_d  = diag_inc;
                    row0_d  = i_min_nxt[LEN_W-1:0];
                    state_d = StRun;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
            r_q     <= '0;
            h_q     <= '0;
            diag_q  <= '0;
            row0_q  <= '0;
            gap_q   <= '0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            h_q     <= h_d;
            diag_q  <= diag_d;
            row0_q  <= row0_d;
            gap_q   <= gap_d;
            rej_q   <= rej_d;
        end
    end

    always_comb begin
        out_valid = (state_q == StRun);
        busy      = (state_q == StRun) || (state_q == StGap);
        done      = (state_q == StFin) || rej_q;
        err       = rej_q;
        out_diag  = diag_q;
        out_row0  = row0_q;
        out_mask  = out_valid ? mask : '0;
        out_last  = out_valid && last_beat;
    end

endmodule
